max_pooling_core: RTL and testbench



---
 rtl/max_pooling_core.sv | 75 +++++++
 tb/tb_max_pooling_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/max_pooling_core.sv
// rtl/max_pooling_core.sv - two-stage 2x2 max-pooling reducer returning the maximum value and its window index
module max_pooling_core #(
    parameter int DATA_W = 36,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] conv_val0,
    input  logic [DATA_W-1:0] conv_val1,
    input  logic [DATA_W-1:0] conv_val2,
    input  logic [DATA_W-1:0] conv_val3,
    output logic              out_valid,
    output logic [DATA_W-1:0] max_val,
    output logic [1:0]        max_idx
);

    // Strict greater-than: a tie never displaces the lower-index candidate.
    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a_val;
    logic [DATA_W-1:0] s1_b_val;
    logic              s1_a_idx;
    logic              s1_b_idx;

    logic a_hi_wins;
    logic b_hi_wins;
    logic pair_b_wins;

    always_comb begin
        a_hi_wins   = greater(conv_val1, conv_val0);
        b_hi_wins   = greater(conv_val3, conv_val2);
        pair_b_wins = greater(s1_b_val, s1_a_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a_val <= '0;
            s1_b_val <= '0;
            s1_a_idx <= 1'b0;
            s1_b_idx <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a_val <= a_hi_wins ? conv_val1 : conv_val0;
                s1_a_idx <= a_hi_wins;
                s1_b_val <= b_hi_wins ? conv_val3 : conv_val2;
                s1_b_idx <= b_hi_wins;
            end
        end
    end

    // Result registers only move on a valid beat so idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            max_val   <= '0;
            max_idx   <= 2'd0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                max_val <= pair_b_wins ? s1_b_val : s1_a_val;
                max_idx <= pair_b_wins ? {1'b1, s1_b_idx} : {1'b0, s1_a_idx};
            end
        end
    end

endmodule

// File: tb/tb_max_pooling_core.sv
// tb/tb_max_pooling_core.sv - scoreboard bench for max_pooling_core, unsigned and signed instances side by side
module tb_max_pooling_core;

    localparam int W = 36;

    typedef struct {
        logic [W-1:0] val;
        logic [1:0]   idx;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] cv0 = '0, cv1 = '0, cv2 = '0, cv3 = '0;

    logic         ov_u, ov_s;
    logic [W-1:0] mv_u, mv_s;
    logic [1:0]   mi_u, mi_s;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;

    exp_t         exp_q[2][$];
    logic [W-1:0] last_val[2] = '{default: '0};
    logic [1:0]   last_idx[2] = '{default: '0};

    always #5 clk = ~clk;

    max_pooling_core #(.DATA_W(W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .conv_val0(cv0), .conv_val1(cv1), .conv_val2(cv2), .conv_val3(cv3),
        .out_valid(ov_u), .max_val(mv_u), .max_idx(mi_u)
    );

    max_pooling_core #(.DATA_W(W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .conv_val0(cv0), .conv_val1(cv1), .conv_val2(cv2), .conv_val3(cv3),
        .out_valid(ov_s), .max_val(mv_s), .max_idx(mi_s)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: linear scan, first index holding the maximum wins.
    function automatic exp_t ref_max(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] c, input logic [W-1:0] d,
                                     input bit signed_mode);
        logic [W-1:0] v[4];
        int best;
        exp_t e;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        best = 0;
        for (int i = 1; i < 4; i++) begin
            if (signed_mode ? ($signed(v[i]) > $signed(v[best])) : (v[i] > v[best]))
                best = i;
        end
        e.val = v[best];
        e.idx = 2'(best);
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic         v;
            logic [W-1:0] val;
            logic [1:0]   idx;
            exp_t         e;
            string        tag;
            v   = (k == 1) ? ov_s : ov_u;
            val = (k == 1) ? mv_s : mv_u;
            idx = (k == 1) ? mi_s : mi_u;
            tag = (k == 1) ? "signed" : "unsigned";
            while (exp_q[k].size() > 0 && exp_q[k][0].cyc < cyc) begin
                e = exp_q[k].pop_front();
                chk(1'b0, {tag, "_missing_result"}, '0, e.val);
            end
            if (rst_q) begin
                chk(v == 1'b0, {tag, "_reset_out_valid"}, W'(v), '0);
                chk(val == '0 && idx == 2'd0, {tag, "_reset_outputs"}, val | W'(idx), '0);
                last_val[k] = '0;
                last_idx[k] = 2'd0;
            end else if (v) begin
                if (exp_q[k].size() == 0 || exp_q[k][0].cyc != cyc) begin
                    chk(1'b0, {tag, "_unexpected_out_valid"}, val, '0);
                end else begin
                    e = exp_q[k].pop_front();
                    chk(val == e.val, {tag, "_max_val"}, val, e.val);
                    chk(idx == e.idx, {tag, "_max_idx"}, W'(idx), W'(e.idx));
                end
                last_val[k] = val;
                last_idx[k] = idx;
            end else begin
                chk(val == last_val[k] && idx == last_idx[k], {tag, "_idle_hold"}, val, last_val[k]);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d, input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = v;
        cv0 = a; cv1 = b; cv2 = c; cv3 = d;
        if (v) begin
            for (int k = 0; k < 2; k++) begin
                e = ref_max(a, b, c, d, k == 1);
                e.cyc = cyc + 2;
                exp_q[k].push_back(e);
            end
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [63:0] r;
        logic [W-1:0] pick[4];
        pick[0] = '0; pick[1] = 36'h800000000; pick[2] = 36'hFFFFFFFFF; pick[3] = 36'h5;
        if ($urandom_range(3, 0) == 0) return pick[$urandom_range(3, 0)];
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Drops every in-flight window; the beat presented alongside rst is not expected either.
    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            in_valid = 1'($urandom_range(1, 0));
            cv0 = rnd_val(); cv1 = rnd_val(); cv2 = rnd_val(); cv3 = rnd_val();
            for (int k = 0; k < 2; k++)
                while (exp_q[k].size() > 0 && exp_q[k][$].cyc > cyc) void'(exp_q[k].pop_back());
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        send(36'd1, 36'd2, 36'd3, 36'd4, 1'b1);
        send(36'hF, 36'hA, 36'hB, 36'hC, 1'b1);
        send(36'h123456789, 36'h987654321, 36'h111111111, 36'h0FFFFFFFF, 1'b1);
        send(36'h555555555, 36'h666666666, 36'h777777777, 36'h088888888, 1'b1);
        send(36'h5, 36'h5, 36'h5, 36'h5, 1'b1);
        send(36'h0, 36'h0, 36'h0, 36'h0, 1'b0);
        send(36'h0, 36'h0, 36'h0, 36'h0, 1'b0);
        send(36'h0, 36'h0, 36'h0, 36'h0, 1'b0);

        send(36'd100, 36'd200, 36'd300, 36'd400, 1'b1);
        apply_reset(1);
        send(36'd1, 36'd1, 36'd1, 36'd1, 1'b0);
        send(36'd1, 36'd1, 36'd1, 36'd1, 1'b0);
        send(36'd9, 36'd8, 36'd7, 36'd6, 1'b1);
        send(36'hFFFFFFFFF, 36'h800000000, 36'h7FFFFFFFF, 36'h0, 1'b1);
        send(36'h0, 36'h0, 36'h0, 36'h0, 1'b0);
        send(36'h0, 36'h0, 36'h0, 36'h0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(49, 0) == 0)
                apply_reset(int'($urandom_range(2, 1)));
            else
                send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), $urandom_range(3, 0) != 0);
        end

        send(36'h0, 36'h0, 36'h0, 36'h0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(exp_q[0].size() == 0, "unsigned_drain", W'(exp_q[0].size()), '0);
        chk(exp_q[1].size() == 0, "signed_drain", W'(exp_q[1].size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
